beta_pc_ctrl: RTL and testbench

Sequencer for the Beta program-counter datapath. It fetches with an instruction-memory handshake, decodes the opcode, and drives the PC block's `PCSEL` and load strobe once per instruction. It stalls on data-memory accesses and redirects to the illegal-opcode or interrupt vector when required, asserting the XP save strobe. It sits between the instruction/data memory interfaces and the PC register block.

---
 rtl/beta_pc_ctrl.sv | 111 +++++++++++
 tb/tb_beta_pc_ctrl.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/beta_pc_ctrl.sv
// beta_pc_ctrl: Beta PC sequencer (fetch/exec/mem), trap and interrupt redirect; IRQ path under `BETA_PC_IRQ_EN
module beta_pc_ctrl (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [5:0] OPCODE,
  input  logic       Z,
  input  logic       PC31,
  input  logic       IRQ,
  input  logic       IMEM_VALID,
  input  logic       DMEM_ACK,
  output logic       IMEM_REQ,
  output logic       DMEM_REQ,
  output logic [3:0] PCSEL,
  output logic       PC_LD,
  output logic       XP_WE,
  output logic       IRQ_ACK,
  output logic [1:0] STATE
);
  typedef enum logic [1:0] {S_RST, S_FETCH, S_EXEC, S_MEM} state_t;
  state_t state_q, state_d;
  logic [5:0] op_q, op_d;
  logic legal, is_mem, take;
  assign legal = (op_q[5] & (op_q[2:0] != 3'b111)) | (op_q == 6'h18) | (op_q == 6'h19) |
                 (op_q == 6'h1B) | (op_q == 6'h1C) | (op_q == 6'h1D) | (op_q == 6'h1F);
  assign is_mem = (op_q == 6'h18) | (op_q == 6'h19) | (op_q == 6'h1F);
  assign STATE = state_q;
`ifdef BETA_PC_IRQ_EN
  logic [2:0] sync_q, sync_d;
  logic pend_q, pend_d;
  assign take = (state_q == S_EXEC) & pend_q & ~PC31;
  // IRQ synchronizer shift and sticky pending; a fresh edge wins over a same-cycle take
  always_comb begin
    sync_d = {sync_q[1:0], IRQ};
    pend_d = (sync_q[1] & ~sync_q[2]) | (pend_q & ~take);
  end
  // IRQ synchronizer and pending registers
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      sync_q <= '0;
      pend_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      pend_q <= pend_d;
    end
  end
`else
  logic unused_irq;
  assign unused_irq = IRQ ^ PC31;
  assign take = 1'b0;
`endif
  // Next state, opcode capture and per-state outputs
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    IMEM_REQ = 1'b0;
    DMEM_REQ = 1'b0;
    PCSEL = 4'd0;
    PC_LD = 1'b0;
    XP_WE = 1'b0;
    IRQ_ACK = 1'b0;
    case (state_q)
      S_RST: state_d = S_FETCH;
      S_FETCH: begin
        IMEM_REQ = 1'b1;
        if (IMEM_VALID) begin
          op_d = OPCODE;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_FETCH;
        PC_LD = 1'b1;
        if (take) begin
          PCSEL = 4'd4;
          XP_WE = 1'b1;
          IRQ_ACK = 1'b1;
        end else if (!legal) begin
          PCSEL = 4'd3;
          XP_WE = 1'b1;
        end else if (is_mem) begin
          PC_LD = 1'b0;
          state_d = S_MEM;
        end else if (op_q == 6'h1C) begin
          PCSEL = Z ? 4'd1 : 4'd0;
        end else if (op_q == 6'h1D) begin
          PCSEL = Z ? 4'd0 : 4'd1;
        end else if (op_q == 6'h1B) begin
          PCSEL = 4'd2;
        end
      end
      S_MEM: begin
        DMEM_REQ = 1'b1;
        if (DMEM_ACK) begin
          PC_LD = 1'b1;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_RST;
    endcase
  end
  // State and opcode registers
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= S_RST;
      op_q <= '0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
    end
  end
endmodule

// File: tb/tb_beta_pc_ctrl.sv
// tb_beta_pc_ctrl: randomized and directed bench for beta_pc_ctrl against an instruction-level model
module tb_beta_pc_ctrl;
`ifdef BETA_PC_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif
  logic CLK = 1'b0, RESET = 1'b0, Z = 1'b0, PC31 = 1'b0, IRQ = 1'b0, IMEM_VALID = 1'b0, DMEM_ACK = 1'b0;
  logic [5:0] OPCODE = '0;
  logic IMEM_REQ, DMEM_REQ, PC_LD, XP_WE, IRQ_ACK;
  logic [3:0] PCSEL;
  logic [1:0] STATE;
  int n_cmp = 0, n_bad = 0;
  int m_ph = 0;
  logic [5:0] m_op = '0;
  logic m_pend = 1'b0;
  logic [2:0] m_h = '0;

  beta_pc_ctrl dut (
    .CLK(CLK), .RESET(RESET), .OPCODE(OPCODE), .Z(Z), .PC31(PC31), .IRQ(IRQ),
    .IMEM_VALID(IMEM_VALID), .DMEM_ACK(DMEM_ACK), .IMEM_REQ(IMEM_REQ), .DMEM_REQ(DMEM_REQ),
    .PCSEL(PCSEL), .PC_LD(PC_LD), .XP_WE(XP_WE), .IRQ_ACK(IRQ_ACK), .STATE(STATE)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_legal(input logic [5:0] op);
    return op inside {6'h18, 6'h19, 6'h1B, 6'h1C, 6'h1D, 6'h1F,
                      [6'h20:6'h26], [6'h28:6'h2E], [6'h30:6'h36], [6'h38:6'h3E]};
  endfunction

  // One cycle: drive inputs after the falling edge, compare against the model, advance the model
  task automatic step(input logic rn, input logic [5:0] op, input logic v, input logic z,
                      input logic p, input logic irq, input logic ack);
    int e_st, e_sel, nph;
    bit e_ir, e_dr, e_ld, e_xp, e_ak, take, npend;
    logic [5:0] nop;
    logic [2:0] nh;
    @(negedge CLK);
    RESET = rn; OPCODE = op; IMEM_VALID = v; Z = z; PC31 = p; IRQ = irq; DMEM_ACK = ack;
    #1;
    e_st = 0; e_sel = 0; e_ir = 0; e_dr = 0; e_ld = 0; e_xp = 0; e_ak = 0; take = 0;
    nph = 0; nop = '0; npend = 0; nh = '0;
    if (rn) begin
      e_st = m_ph; nph = m_ph; nop = m_op;
      if (m_ph == 0) nph = 1;
      else if (m_ph == 1) begin
        e_ir = 1;
        if (v) begin nop = op; nph = 2; end
      end else if (m_ph == 2) begin
        take = IRQ_EN && m_pend && !p;
        nph = 1; e_ld = 1;
        if (take) begin e_sel = 4; e_xp = 1; e_ak = 1; end
        else if (!is_legal(m_op)) begin e_sel = 3; e_xp = 1; end
        else if (m_op inside {6'h18, 6'h19, 6'h1F}) begin e_ld = 0; nph = 3; end
        else if (m_op == 6'h1C) e_sel = z ? 1 : 0;
        else if (m_op == 6'h1D) e_sel = z ? 0 : 1;
        else if (m_op == 6'h1B) e_sel = 2;
      end else begin
        e_dr = 1;
        if (ack) begin e_ld = 1; nph = 1; end
      end
      npend = IRQ_EN && ((m_h[1] && !m_h[2]) || (m_pend && !take));
      nh = {m_h[1:0], irq};
    end
    chk("STATE", int'(STATE), e_st);
    chk("IMEM_REQ", int'(IMEM_REQ), int'(e_ir));
    chk("DMEM_REQ", int'(DMEM_REQ), int'(e_dr));
    chk("PCSEL", int'(PCSEL), e_sel);
    chk("PC_LD", int'(PC_LD), int'(e_ld));
    chk("XP_WE", int'(XP_WE), int'(e_xp));
    chk("IRQ_ACK", int'(IRQ_ACK), int'(e_ak));
    m_ph = nph; m_op = nop; m_pend = npend; m_h = nh;
  endtask

  task automatic instr(input logic [5:0] op, input logic z, input logic p, input logic irq);
    step(1, op, 1, z, p, irq, 0);
    step(1, '0, 0, z, p, irq, 0);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) step(0, '0, 0, 0, 0, 0, 0);
    chk("rst_state", int'(STATE), 0);
    chk("rst_imem", int'(IMEM_REQ), 0);
    chk("rst_pcld", int'(PC_LD), 0);
    step(1, '0, 0, 0, 0, 0, 0);
    chk("rel_state", int'(STATE), 0);
    step(1, '0, 0, 0, 0, 0, 0);
    chk("fetch_state", int'(STATE), 1);
    chk("fetch_imem", int'(IMEM_REQ), 1);
    instr(6'h20, 0, 0, 0);
    chk("alu_pcsel", int'(PCSEL), 0);
    chk("alu_pcld", int'(PC_LD), 1);
    instr(6'h1C, 1, 0, 0);
    chk("beq_pcsel", int'(PCSEL), 1);
    instr(6'h1D, 1, 0, 0);
    chk("bne_pcsel", int'(PCSEL), 0);
    chk("bne_pcld", int'(PC_LD), 1);
    instr(6'h18, 0, 0, 0);
    chk("ld_exec_pcld", int'(PC_LD), 0);
    for (int i = 0; i < 4; i++) begin
      step(1, '0, 0, 0, 0, 0, 0);
      chk("stall_dreq", int'(DMEM_REQ), 1);
      chk("stall_pcld", int'(PC_LD), 0);
    end
    step(1, '0, 0, 0, 0, 0, 1);
    chk("ack_pcld", int'(PC_LD), 1);
    chk("ack_pcsel", int'(PCSEL), 0);
    step(1, '0, 0, 0, 0, 0, 0);
    chk("ack_next_state", int'(STATE), 1);
    instr(6'h00, 0, 0, 0);
    chk("ill_pcsel", int'(PCSEL), 3);
    chk("ill_xp", int'(XP_WE), 1);
    chk("ill_ack", int'(IRQ_ACK), 0);
    instr(6'h18, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      step(1, '0, 0, 0, 0, 1, 0);
      chk("mem_no_trap", int'(PCSEL), 0);
    end
    step(1, '0, 0, 0, 0, 1, 1);
    instr(6'h20, 0, 0, 1);
    chk("irq_pcsel", int'(PCSEL), IRQ_EN ? 4 : 0);
    chk("irq_xp", int'(XP_WE), IRQ_EN ? 1 : 0);
    chk("irq_ack", int'(IRQ_ACK), IRQ_EN ? 1 : 0);
    instr(6'h20, 0, 0, 1);
    chk("post_irq_pcsel", int'(PCSEL), 0);
    instr(6'h20, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      instr(6'h21, 0, 1, 1);
      chk("sup_pcsel", int'(PCSEL), 0);
      chk("sup_ack", int'(IRQ_ACK), 0);
    end
    instr(6'h21, 0, 0, 1);
    chk("unmask_pcsel", int'(PCSEL), IRQ_EN ? 4 : 0);
    chk("unmask_ack", int'(IRQ_ACK), IRQ_EN ? 1 : 0);
    begin
      logic irq_r = 1'b1, p_r = 1'b0;
      for (int i = 0; i < 3000; i++) begin
        logic [5:0] op;
        if ($urandom_range(0, 14) == 0) irq_r = ~irq_r;
        if ($urandom_range(0, 29) == 0) p_r = ~p_r;
        case ($urandom_range(0, 3))
          0: op = 6'($urandom_range(0, 63));
          1: op = ($urandom_range(0, 2) == 0) ? 6'h1F : 6'h18 + 6'($urandom_range(0, 1));
          2: op = 6'h1B + 6'($urandom_range(0, 2));
          default: op = 6'h20 + 6'($urandom_range(0, 31));
        endcase
        step($urandom_range(0, 199) != 0, op, $urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)),
             p_r, irq_r, $urandom_range(0, 2) == 0);
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
